m68k_bus_master: RTL
====================

M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have: RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: REQ  in  1  start-transfer strobe, sampled only in IDLE.
REQ-004 SHALL have: WE  in  1  1=write, 0=read.
REQ-005 SHALL have: SIZE  in  1  1=word, 0=byte.
REQ-006 SHALL have: ADDR_REQ  in  24  byte address.
REQ-007 SHALL have: WDATA  in  16  write data; byte writes use WDATA[7:0].
REQ-008 SHALL have: BUSY  out  1  high from REQ accept until return to IDLE.
REQ-009 SHALL have: DONE  out  1  one-cycle completion pulse.
REQ-010 SHALL have: ERR  out  1  valid with DONE; 1=aborted transfer.
REQ-011 SHALL have: RDATA  out  16  read result, held until next DONE.
REQ-012 SHALL have: ADDR_OUT  out  23  bus address A23..A1.
REQ-013 SHALL have: DATA_OUT  out  16 and DATA_OE  out  1  bus write data and its enable.
REQ-014 SHALL have: DATA_IN  in  16  bus read data.
REQ-015 SHALL have: AS, UDS, LDS  out  1 each  active-low strobes; RW  out  1  (1=read); DTACK  in  1  active-low acknowledge.

Function
REQ-016 SHALL implement states IDLE, ADDR, ASSERT, WAIT, TERM, RECOVER.
REQ-017 IDLE with REQ=1: latch WE/SIZE/ADDR_REQ/WDATA, BUSY=1, go to ADDR; REQ while BUSY SHALL be ignored.
REQ-018 Word request with ADDR_REQ[0]=1 SHALL skip the bus (no strobe asserted), go directly to TERM with ERR=1.
REQ-019 ADDR: drive ADDR_OUT=ADDR_REQ[23:1] and RW=~WE; AS/UDS/LDS stay high.
REQ-020 ASSERT: AS=0; read asserts selected data strobes; write asserts DATA_OE=1, data strobes stay high.
REQ-021 WAIT: AS and selected data strobes low; advance to TERM on the first edge DTACK is sampled 0.
REQ-022 Strobe selection: word=UDS+LDS; byte A0=0 -> UDS only; byte A0=1 -> LDS only.
REQ-023 Byte write SHALL drive DATA_OUT={WDATA[7:0],WDATA[7:0]}; word write DATA_OUT=WDATA.
REQ-024 Read SHALL capture DATA_IN on the edge DTACK is sampled 0; byte read RDATA={8'h00, selected half}.
REQ-025 TERM: AS/UDS/LDS high, DATA_OE=0, DONE=1 for exactly one cycle; ADDR_OUT and RW hold.
REQ-026 RECOVER: remain until DTACK sampled 1, then IDLE with BUSY=0.
REQ-027 Minimum latency: REQ accepted edge N, DTACK already low -> DONE high in cycle N+4, BUSY low at N+5.

Reset
REQ-028 RST=1 SHALL force IDLE on the next edge from any state, including mid-cycle: AS/UDS/LDS/RW=1, DATA_OE=0, BUSY/DONE/ERR=0, RDATA=0, ADDR_OUT=0, DATA_OUT=0; no DONE for the aborted transfer.

Configuration
REQ-029 Macro M68K_BUS_TIMEOUT_EN defined: a counter in WAIT SHALL abort after 64 cycles without DTACK, going to TERM with ERR=1 and RDATA unchanged.
REQ-030 Macro undefined: WAIT SHALL persist indefinitely; ERR SHALL arise only from REQ-018.

Structure
REQ-031 Package m68k_bus_pkg SHALL hold the state enum, SIZE encoding constants, and the timeout length (64).
REQ-032 Timeout counter SHALL be sub-module m68k_bus_timeout (clear, enable, expired), instantiated only with M68K_BUS_TIMEOUT_EN.

Verification
REQ-033 Word read 0x120034, responder DTACK=0 in WAIT with DATA_IN=0xBEEF -> UDS+LDS low, RDATA=0xBEEF, DONE at N+4, ERR=0.
REQ-034 Byte write 0x120035, WDATA=0x00A5 -> only LDS low, DATA_OUT=0xA5A5, DATA_OE=1 ASSERT..WAIT, RW=0.
REQ-035 Word read 0x000001 -> no AS/UDS/LDS assertion, DONE+ERR=1 after ADDR.
REQ-036 DTACK held high (macro defined) -> DONE+ERR after 64 WAIT cycles; (undefined) -> BUSY stays 1 for 200 cycles.
REQ-037 RST pulse during WAIT -> all strobes high next edge, no DONE; subsequent byte read 0x000010 completes normally via UDS.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-style bus master.
// Optional feature macro: M68K_BUS_TIMEOUT_EN (bounds the WAIT state by TimeoutCycles).
package m68k_bus_pkg;

    // Bus cycle phases
    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAssert,
        StWait,
        StTerm,
        StRecover
    } bus_state_e;

    // SIZE input encoding
    localparam logic SizeByte = 1'b0;
    localparam logic SizeWord = 1'b1;

    // WAIT cycles without DTACK before an abort
    localparam int unsigned TimeoutCycles = 64;
    localparam int unsigned TimeoutWidth  = $clog2(TimeoutCycles);

    // Data strobe select as {upper, lower}, active-high
    function automatic logic [1:0] strobe_sel(input logic size, input logic a0);
        if (size == SizeWord) begin
            return 2'b11;
        end else if (a0) begin
            return 2'b01;
        end else begin
            return 2'b10;
        end
    endfunction

endpackage

// File: rtl/m68k_bus_timeout.sv
// WAIT-state watchdog: counts enabled cycles, flags the last allowed one.
// Only instantiated when M68K_BUS_TIMEOUT_EN is defined.
module m68k_bus_timeout
    import m68k_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TimeoutWidth-1:0] count_q;

    // Cycle counter, cleared whenever the master is outside WAIT
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    // High during the final WAIT cycle, so the abort lands after exactly TimeoutCycles
    assign expired = enable && (count_q == TimeoutWidth'(TimeoutCycles - 1));

endmodule

// File: rtl/m68k_bus_master.sv
// Single-transfer 68000-style asynchronous bus master.
// Optional feature macro: M68K_BUS_TIMEOUT_EN (abort WAIT after TimeoutCycles without DTACK).
module m68k_bus_master
    import m68k_bus_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic        SIZE,
    input  logic [23:0] ADDR_REQ,
    input  logic [15:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic [22:0] ADDR_OUT,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    input  logic        DTACK
);

    bus_state_e  state_q, state_d;
    logic        we_q, size_q, a0_q, err_q, rw_q;
    logic [22:0] addr_q;
    logic [15:0] dout_q, rdata_q;
    logic        accept, capture, set_err;
    logic [1:0]  sel;
    logic        tmo_expired;

`ifdef M68K_BUS_TIMEOUT_EN
    m68k_bus_timeout u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .clear   (state_q != StWait),
        .enable  (state_q == StWait),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    assign sel      = strobe_sel(size_q, a0_q);
    assign ADDR_OUT = addr_q;
    assign DATA_OUT = dout_q;
    assign RDATA    = rdata_q;
    assign RW       = rw_q;

    // State register and latched transfer attributes
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= SizeByte;
            a0_q    <= 1'b0;
            err_q   <= 1'b0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q   <= WE;
                size_q <= SIZE;
                a0_q   <= ADDR_REQ[0];
                err_q  <= 1'b0;
                rw_q   <= ~WE;
                addr_q <= ADDR_REQ[23:1];
                // Byte writes replicate onto both lanes so either strobe sees the data
                dout_q <= (SIZE == SizeWord) ? WDATA : {WDATA[7:0], WDATA[7:0]};
            end else if (state_q == StRecover && DTACK) begin
                rw_q <= 1'b1;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (capture) begin
                rdata_q <= (size_q == SizeWord) ? DATA_IN :
                           {8'h00, (a0_q ? DATA_IN[7:0] : DATA_IN[15:8])};
            end
        end
    end

    // Next-state logic and Moore-style bus strobes
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        set_err = 1'b0;
        BUSY    = (state_q != StIdle);
        DONE    = 1'b0;
        ERR     = 1'b0;
        AS      = 1'b1;
        UDS     = 1'b1;
        LDS     = 1'b1;
        DATA_OE = 1'b0;
        case (state_q)
            StIdle: begin
                if (REQ) begin
                    accept  = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                // Misaligned word never touches the bus
                if (size_q == SizeWord && a0_q) begin
                    set_err = 1'b1;
                    state_d = StTerm;
                end else begin
                    state_d = StAssert;
                end
            end
            StAssert: begin
                AS = 1'b0;
                if (we_q) begin
                    DATA_OE = 1'b1;
                end else begin
                    UDS = ~sel[1];
                    LDS = ~sel[0];
                end
                state_d = StWait;
            end
            StWait: begin
                AS      = 1'b0;
                UDS     = ~sel[1];
                LDS     = ~sel[0];
                DATA_OE = we_q;
                if (!DTACK) begin
                    capture = ~we_q;
                    state_d = StTerm;
                end else if (tmo_expired) begin
                    set_err = 1'b1;
                    state_d = StTerm;
                end
            end
            StTerm: begin
                DONE    = 1'b1;
                ERR     = err_q;
                state_d = StRecover;
            end
            StRecover: begin
                if (DTACK) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
